// File: rtl/adc_spi_arbiter.sv
// rtl/adc_spi_arbiter.sv - round-robin arbiter sharing one ADC SPI master between requesters
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/data    per-requester command requests (requester i owns req_data[i*CMD_W +: CMD_W])
//   req_ready         one-hot single-cycle command-accept strobe
//   rsp_valid         one-hot single-cycle response strobe to the issuing requester
//   rsp_data          response frame (0 on timeout), held until the next response
//   rsp_timeout       set with rsp_valid when the transaction timed out
//   spi_wr, spi_din   write strobe and 16-bit frame to the SPI master
//   spi_ready         SPI master idle
//   spi_dout_valid    SPI master frame-complete strobe, spi_dout the received frame
//   busy              arbiter not idle
//   grant_id          current/last granted requester
//   timeout_cnt       saturating count of timed-out transactions
module adc_spi_arbiter #(
  parameter int NREQ    = 3,
  parameter int CMD_W   = 24,
  parameter int TIMEOUT = 4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CMD_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [15:0]           rsp_data,
  output logic                  rsp_timeout,
  output logic                  spi_wr,
  output logic [15:0]           spi_din,
  input  logic                  spi_ready,
  input  logic                  spi_dout_valid,
  input  logic [15:0]           spi_dout,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic [7:0]            timeout_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAST_ID  = 2'(NREQ - 1);

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q;
  logic [1:0]         ptr_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               gnt_found;
  logic [1:0]         gnt_idx;
  logic [1:0]         cand;
  logic [CMD_W-1:0]   req_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*CMD_W +: CMD_W];
  end

  // Only the upper 16 bits of a command go on the wire; the low byte is
  // carried in the command register but has no consumer here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_q[CMD_W-17:0];

  assign spi_din = cmd_q[CMD_W-1 -: 16];

  // Round-robin search: walk NREQ candidates starting at the pointer,
  // wrapping at the last requester, and take the first one requesting.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == LAST_ID) ? 2'd0 : cand + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    spi_wr    = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready = NREQ'(1) << gnt_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        spi_wr = spi_ready;
        if (spi_ready) state_d = WAIT;
      end
      WAIT: begin
        // Returned data takes precedence over a simultaneous timeout.
        if (spi_dout_valid || wait_cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        rsp_valid = NREQ'(1) << grant_id;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      ptr_q       <= 2'd0;
      grant_id    <= 2'd0;
      wait_cnt    <= '0;
      rsp_data    <= 16'h0000;
      rsp_timeout <= 1'b0;
      timeout_cnt <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            cmd_q    <= req_arr[gnt_idx];
            grant_id <= gnt_idx;
            ptr_q    <= (gnt_idx == LAST_ID) ? 2'd0 : gnt_idx + 2'd1;
          end
        end
        ISSUE: begin
          if (spi_ready) wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (spi_dout_valid) begin
            rsp_data    <= spi_dout;
            rsp_timeout <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_data    <= 16'h0000;
            rsp_timeout <= 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adc_spi_arbiter.md
Name: adc_spi_arbiter

Overview:
- Shares the single ADC SPI master (16-bit frames) between NREQ requesters: bus register writes, the auto-configuration sequencer, and the periodic status poller.
- Uses round-robin arbitration, one outstanding SPI transaction at a time, and a per-transaction response timeout.
- Routes each response back to the requester that issued the command.
- Sits between the ADC configuration logic and the SPI master, in the clk domain.

Parameters:
- NREQ, 3, number of requesters; index 0 has highest priority immediately after reset.
- CMD_W, 24, command word width; bits [23:8] form the SPI frame.
- TIMEOUT, 4000, maximum clk cycles spent in WAIT before the transaction is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester command request; held until the matching req_ready
- req_data  in  NREQ*CMD_W  commands; requester i uses [i*CMD_W +: CMD_W]
- req_ready  out  NREQ  one-hot, single-cycle command-accept strobe
- rsp_valid  out  NREQ  one-hot, single-cycle response strobe to the issuing requester
- rsp_data  out  16  response data; valid while any rsp_valid bit is high
- rsp_timeout  out  1  high together with rsp_valid when the transaction timed out
- spi_wr  out  1  single-cycle write strobe to the SPI master
- spi_din  out  16  frame to the SPI master
- spi_ready  in  1  SPI master idle and able to accept spi_wr
- spi_dout_valid  in  1  SPI master frame-complete strobe
- spi_dout  in  16  SPI master received frame
- busy  out  1  high whenever state is not IDLE
- grant_id  out  2  index of the current/last granted requester
- timeout_cnt  out  8  saturating count of timed-out transactions

Behaviour:
- Reset values: state IDLE; req_ready, rsp_valid, spi_wr, busy, rsp_timeout all 0; rsp_data 0; grant_id 0; timeout_cnt 0; round-robin pointer 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - Search starts at the pointer and wraps modulo NREQ; the first requester with req_valid=1 is granted (g).
  - req_ready[g]=1 combinationally in that same cycle.
  - On that edge: latch req_data[g] into the command register, set grant_id=g, set the pointer to (g+1) mod NREQ, go to ISSUE.
  - No req_valid: stay in IDLE, req_ready=0.
  - A requester dropping req_valid before it is granted is legal; nothing is captured for it.
- ISSUE
  - spi_wr = spi_ready, combinational from state; spi_din = command[23:8] at all times.
  - spi_ready=1: go to WAIT and clear the timeout counter.
  - spi_ready=0: stay in ISSUE indefinitely; no timeout applies in ISSUE.
- WAIT
  - Counter increments every cycle.
  - spi_dout_valid=1: latch spi_dout into rsp_data, rsp_timeout=0, go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1: rsp_data=0, rsp_timeout=1, timeout_cnt+1 (saturates at 255), go to DONE.
  - spi_dout_valid and the timeout limit in the same cycle: data wins, no timeout recorded.
  - spi_dout_valid outside WAIT is ignored.
- DONE
  - rsp_valid[grant_id]=1 for exactly one cycle; rsp_data and rsp_timeout hold until the next DONE.
  - Next state is IDLE; arbitration resumes the following cycle.
- Latency (no contention, spi_ready=1): req_ready at cycle t, spi_wr at t+1, rsp_valid 1 cycle after the spi_dout_valid cycle.
- Minimum spacing between grants: 4 cycles.
- Fairness: a requester holding req_valid is granted within NREQ transactions.
- rst in any state: return to IDLE the next cycle and drop spi_wr; the in-flight response is discarded and never reported. The SPI master shares rst.
- grant_id is 2 bits wide, so NREQ <= 4.

Test Plan:
- Single request: req_valid[1]=1, req_data[1]=24'h801234 -> req_ready[1] same cycle, spi_wr one cycle later with spi_din=16'h8012. Model returns 16'h00AB after 34 cycles -> rsp_valid[1] pulse, rsp_data=16'h00AB, rsp_timeout=0.
- Contention: all three requests held continuously -> grant order 0,1,2,0,1,2; each req_ready occurs only after the previous rsp_valid.
- Timeout: no spi_dout_valid returned -> rsp_valid with rsp_timeout=1 and rsp_data=0 exactly TIMEOUT cycles after entering WAIT; timeout_cnt=1. Repeat 300 times -> timeout_cnt saturates at 255.
- Back-pressure: spi_ready=0 for 50 cycles after a grant -> no spi_wr and no timeout; spi_wr fires in the cycle spi_ready rises.
- Race: spi_dout_valid arrives on cycle TIMEOUT-1 of WAIT -> data response, rsp_timeout=0, timeout_cnt unchanged.
- Reset mid-WAIT: assert rst for 1 cycle -> busy=0 the next cycle, no rsp_valid for the aborted transaction, pointer=0; a following request from requester 2 completes normally.
